pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Sequencing controller for the fetch-stage program counter register.
- Drives its next-PC value and write-enable, and runs the req/ack handshake with instruction memory.
- Holds the fetched instruction against decode stalls and steers the PC on branch redirect, exception entry and eret.
- Discards any in-flight fetch that a redirect has made stale.

Parameters:
- RESET_PC, 32'h00003000, reset value of if_pc_o and epc_o; equals the PC register's reset value.
- EXC_VECTOR, 32'h00004180, exception entry address.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pc_i  input  32  current PC from the PC register
- pcplus_i  input  32  pc_i+4 from the PC register
- npc_o  output  32  next PC to the PC register (combinational)
- pc_en_o  output  1  PC register write enable (combinational)
- imem_req_o  output  1  fetch request; held until ack
- imem_addr_o  output  32  fetch address
- imem_ack_i  input  1  fetch complete; rdata valid this cycle
- imem_rdata_i  input  32  fetched word
- stall_i  input  1  decode not accepting
- redirect_i  input  1  taken branch/jump
- redirect_pc_i  input  32  branch/jump target
- exc_i  input  1  take exception
- exc_pc_i  input  32  PC to save in EPC
- eret_i  input  1  return from exception
- if_valid_o  output  1  if_instr_o/if_pc_o valid to decode
- if_instr_o  output  32  fetched instruction
- if_pc_o  output  32  PC of if_instr_o
- epc_o  output  32  saved exception PC
- adel_o  output  1  misaligned-target flag; see Optional Feature

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high. Reset values: state=IDLE; imem_req_o=0; if_valid_o=0; if_instr_o=0; if_pc_o=RESET_PC; epc_o=RESET_PC; drain_addr=0; adel_o=0.
- States: IDLE, REQ, HOLD, DRAIN.
- imem_req_o=1 in REQ and DRAIN only.
- imem_addr_o = drain_addr in DRAIN, else pc_i.
- Event priority: exc_i > eret_i > redirect_i > sequential. Targets:
  - exc: EXC_VECTOR; epc_o<=exc_pc_i on the same edge.
  - eret: current epc_o.
  - redirect: redirect_pc_i.
- Any event in REQ/HOLD/DRAIN: pc_en_o=1, npc_o=target, if_valid_o<=0.
- Events in IDLE are ignored; pc_en_o=0.
- IDLE: go to REQ unconditionally next cycle.
- REQ, ack & !event & !stall_i:
  - pc_en_o=1, npc_o=pcplus_i.
  - if_instr_o<=imem_rdata_i, if_pc_o<=pc_i, if_valid_o<=1.
  - Stay in REQ; back-to-back fetch gives 1 instruction/cycle with a zero-wait memory.
- REQ, ack & !event & stall_i: capture as above, pc_en_o=0, go to HOLD.
- REQ, no ack & !event: stay; if_valid_o<=0 when !stall_i, else hold.
- REQ, event & no ack: drain_addr<=pc_i, go to DRAIN (request stays outstanding).
- REQ, event & ack: discard data, stay in REQ.
- HOLD:
  - if_valid_o=1; outputs frozen.
  - !stall_i & !event: pc_en_o=1, npc_o=pcplus_i, go to REQ; if_valid_o<=0 unless refilled later.
  - event: go to REQ, ignoring stall.
- DRAIN:
  - Keep req at drain_addr; never capture.
  - On ack: go to REQ.
  - Further events still update the PC and remain in DRAIN.
- pc_en_o=0 in every case not listed above; npc_o=pcplus_i when no event.
- Simultaneous exc_i and eret_i: exception taken; epc_o overwritten.
- Reset mid-fetch: state returns to IDLE immediately; the outstanding memory transaction is the memory's responsibility (reset shared).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If the selected redirect/eret target has bits[1:0]!=0, exception entry replaces it: npc_o=EXC_VECTOR, epc_o<=faulting target.
  - adel_o pulses 1 for one cycle after the edge.
  - Exception targets are never checked.
- Undefined: targets pass unchanged; adel_o tied 0.

Test Plan:
- Reset, zero-wait memory (ack every cycle), no stall -> imem_addr 0x3000,0x3004,0x3008 on consecutive cycles; if_pc_o follows one cycle later with if_valid_o=1.
- stall_i=1 for 3 cycles when the word at 0x3004 arrives -> HOLD; if_pc_o=0x3004 and if_valid_o=1 held; pc_en_o=0; on release PC becomes 0x3008.
- Memory with 3-cycle latency; redirect_i to 0x3100 one cycle into the 0x3008 fetch -> DRAIN keeps addr 0x3008 until ack, its data not captured; next request at 0x3100.
- exc_i with exc_pc_i=0x300C, then eret_i several cycles later -> npc 0x4180 then epc_o=0x300C; fetch resumes at 0x300C.
- exc_i and eret_i in the same cycle -> npc 0x4180, epc_o updated.
- PC_ALIGN_CHECK_EN defined, redirect to 0x3102 -> npc 0x4180, epc_o=0x3102, adel_o=1 for one cycle; undefined -> npc 0x3102, adel_o=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus between pc_fetch_ctrl (master) and instruction memory (slave).
interface pc_fetch_ctrl_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;

   modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_rdata_i);
   modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_rdata_i);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: imem req/ack handshake, decode hold, redirect/exception/eret steering.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned redirect/eret targets into exception entry.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            pc_i,
   input  logic [31:0]            pcplus_i,
   output logic [31:0]            npc_o,
   output logic                   pc_en_o,
   pc_fetch_ctrl_if.master        imem,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [31:0]            redirect_pc_i,
   input  logic                   exc_i,
   input  logic [31:0]            exc_pc_i,
   input  logic                   eret_i,
   output logic                   if_valid_o,
   output logic [31:0]            if_instr_o,
   output logic [31:0]            if_pc_o,
   output logic [31:0]            epc_o,
   output logic                   adel_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_t;

   state_t      state_r, state_nxt_s;
   logic [31:0] drain_addr_r, if_instr_r, if_pc_r, epc_r;
   logic        if_valid_r;
   logic        ev_s, misalign_s, pc_en_s, capture_s, drain_load_s, valid_nxt_s;
   logic [31:0] raw_target_s, target_s;

   // Event detection and target selection, exc > eret > redirect
   always_comb begin
      ev_s = (state_r != IDLE) && (exc_i || eret_i || redirect_i);
      if (exc_i) begin
         raw_target_s = EXC_VECTOR;
      end else if (eret_i) begin
         raw_target_s = epc_r;
      end else begin
         raw_target_s = redirect_pc_i;
      end
`ifdef PC_ALIGN_CHECK_EN
      misalign_s = !exc_i && (raw_target_s[1:0] != 2'b00);
`else
      misalign_s = 1'b0;
`endif
      if (misalign_s) begin
         target_s = EXC_VECTOR;
      end else begin
         target_s = raw_target_s;
      end
   end

   // Next-state and handshake decisions
   always_comb begin
      state_nxt_s  = state_r;
      pc_en_s      = 1'b0;
      capture_s    = 1'b0;
      drain_load_s = 1'b0;
      valid_nxt_s  = if_valid_r;
      case (state_r)
         IDLE: begin
            state_nxt_s = REQ;
         end
         REQ: begin
            if (ev_s) begin
               pc_en_s     = 1'b1;
               valid_nxt_s = 1'b0;
               if (imem.imem_ack_i) begin
                  state_nxt_s = REQ;
               end else begin
                  // the outstanding request is now stale; wait it out at its own address
                  drain_load_s = 1'b1;
                  state_nxt_s  = DRAIN;
               end
            end else if (imem.imem_ack_i) begin
               capture_s   = 1'b1;
               valid_nxt_s = 1'b1;
               if (stall_i) begin
                  state_nxt_s = HOLD;
               end else begin
                  pc_en_s = 1'b1;
               end
            end else if (!stall_i) begin
               valid_nxt_s = 1'b0;
            end else begin
               valid_nxt_s = if_valid_r;
            end
         end
         HOLD: begin
            if (ev_s || !stall_i) begin
               pc_en_s     = 1'b1;
               valid_nxt_s = 1'b0;
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         DRAIN: begin
            if (ev_s) begin
               pc_en_s     = 1'b1;
               valid_nxt_s = 1'b0;
            end else begin
               valid_nxt_s = if_valid_r;
            end
            if (imem.imem_ack_i) begin
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and fetch-side registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         drain_addr_r <= 32'h0000_0000;
         if_valid_r   <= 1'b0;
         if_instr_r   <= 32'h0000_0000;
         if_pc_r      <= RESET_PC;
         epc_r        <= RESET_PC;
      end else begin
         state_r    <= state_nxt_s;
         if_valid_r <= valid_nxt_s;
         if (drain_load_s) begin
            drain_addr_r <= pc_i;
         end
         if (capture_s) begin
            if_instr_r <= imem.imem_rdata_i;
            if_pc_r    <= pc_i;
         end
         if (ev_s && exc_i) begin
            epc_r <= exc_pc_i;
         end else if (ev_s && misalign_s) begin
            epc_r <= raw_target_s;
         end
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic adel_r;

   // One-cycle address-error pulse after a misaligned target is replaced
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adel_r <= 1'b0;
      end else begin
         adel_r <= ev_s && misalign_s;
      end
   end
   assign adel_o = adel_r;
`else
   assign adel_o = 1'b0;
`endif

   assign npc_o            = ev_s ? target_s : pcplus_i;
   assign pc_en_o          = pc_en_s;
   assign imem.imem_req_o  = (state_r == REQ) || (state_r == DRAIN);
   assign imem.imem_addr_o = (state_r == DRAIN) ? drain_addr_r : pc_i;
   assign if_valid_o       = if_valid_r;
   assign if_instr_o       = if_instr_r;
   assign if_pc_o          = if_pc_r;
   assign epc_o            = epc_r;

endmodule
